// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding and bus widths for the memory arbiter
package mem_arb_pkg;
  localparam int AW = 16;
  localparam int DW = 16;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: access watchdog, only built when MEM_ARB_TIMEOUT_EN is defined
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // expires on the cycle that would make TIMEOUT_CYCLES stalled access cycles
  assign expired = tick && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // clear on access start, count each stalled access cycle
  always_comb cnt_d = start ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
  // counter register, synchronous active-low reset
  always_ff @(posedge clk)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one memory port; watchdog under MEM_ARB_TIMEOUT_EN
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D_BURST_MAX    = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          if_stall,
  output logic          d_stall,
  output logic          busy,
  output logic          timeout_err
);
  localparam int BW = $clog2(D_BURST_MAX + 1);

  state_t        state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          acc, grant, fetch_win, done, expired;

  assign acc       = state_q != IDLE;
  // the ready-pulse cycle is skipped so a still-held req is not granted twice
  assign grant     = !acc && (if_req || d_req) && !if_ready_q && !d_ready_q;
  assign fetch_win = if_req && (!d_req || burst_cnt_q == BW'(D_BURST_MAX));
  assign done      = acc && (mem_ready || expired);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (grant),
    .tick    (acc && !mem_ready),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES > 0;
  assign expired        = 1'b0;
`endif

  // grant selection, access completion and burst accounting
  always_comb begin
    state_d       = state_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ready_d    = 1'b0;
    d_ready_d     = 1'b0;
    burst_cnt_d   = (!acc && !if_req) ? '0 : burst_cnt_q;
    timeout_err_d = timeout_err_q;
    if (grant) begin
      state_d     = fetch_win ? IF_ACC : D_ACC;
      mem_addr_d  = fetch_win ? if_addr : d_addr;
      mem_we_d    = !fetch_win && d_we;
      mem_wdata_d = fetch_win ? '0 : d_wdata;
      burst_cnt_d = (fetch_win || !if_req) ? '0 :
                    (burst_cnt_q == BW'(D_BURST_MAX)) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end
    if (done) begin
      state_d       = IDLE;
      if_ready_d    = state_q == IF_ACC;
      d_ready_d     = state_q == D_ACC;
      if_rdata_d    = (state_q == IF_ACC) ? (expired ? '0 : mem_rdata) : if_rdata_q;
      d_rdata_d     = (state_q == D_ACC && (expired || !mem_we_q)) ? (expired ? '0 : mem_rdata) : d_rdata_q;
      timeout_err_d = timeout_err_q || expired;
    end
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk)
    if (!rst) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_ready_q    <= 1'b0;
      d_ready_q     <= 1'b0;
      burst_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ready_q    <= if_ready_d;
      d_ready_q     <= d_ready_d;
      burst_cnt_q   <= burst_cnt_d;
      timeout_err_q <= timeout_err_d;
    end

  assign mem_req     = acc;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ready    = if_ready_q;
  assign d_ready     = d_ready_q;
  assign if_stall    = if_req && !if_ready_q;
  assign d_stall     = d_req && !d_ready_q;
  assign busy        = acc;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, if_stall, d_stall, busy, timeout_err;
  int          tests = 0;
  int          fails = 0;

  mem_arbiter #(.D_BURST_MAX(4), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .d_stall(d_stall), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_readys", {if_ready, d_ready}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b1;

    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 16'h0010);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_stall", if_stall, 1);
    chk("fetch_ready_early", if_ready, 0);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("fetch_ready", if_ready, 1);
    chk("fetch_rdata", if_rdata, 16'hBEEF);
    chk("fetch_stall_low", if_stall, 0);
    chk("fetch_mem_req_off", mem_req, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("fetch_ready_pulse", if_ready, 0);
    chk("fetch_idle", busy, 0);

    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    @(negedge clk);
    chk("coll_d_first", mem_addr, 16'h0030);
    chk("coll_if_stall_a", if_stall, 1);
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    @(negedge clk);
    chk("coll_d_ready", d_ready, 1);
    chk("coll_d_rdata", d_rdata, 16'h1111);
    chk("coll_no_grant", mem_req, 0);
    chk("coll_if_stall_b", if_stall, 1);
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("coll_gap", mem_req, 0);
    chk("coll_if_stall_c", if_stall, 1);
    @(negedge clk);
    chk("coll_fetch_grant", {mem_req, mem_addr}, {1'b1, 16'h0020});
    chk("coll_if_stall_d", if_stall, 1);
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    @(negedge clk);
    chk("coll_if_ready", if_ready, 1);
    chk("coll_if_rdata", if_rdata, 16'h2222);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    for (int g = 0; g < 7; g++) begin
      int n = 0;
      while (!mem_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("starve_mem_req", mem_req, 1);
      chk("starve_grant_addr", mem_addr, (g == 4) ? 16'h0100 : 16'h0200);
      mem_ready = 1'b1; mem_rdata = 16'h5000 + 16'(g);
      @(negedge clk);
      mem_ready = 1'b0;
      if (g == 4) begin
        chk("starve_if_ready", {if_ready, d_ready}, 2'b10);
        if_req = 1'b0;
      end else begin
        chk("starve_d_ready", {if_ready, d_ready}, 2'b01);
        if (g == 6) d_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("starve_last_rdata", d_rdata, 16'h5006);

    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0042; d_wdata = 16'h1234; mem_rdata = 16'hDEAD;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      chk("wr_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0042, 16'h1234});
      chk("wr_no_ready", d_ready, 0);
      if (w < 3) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wr_d_ready", d_ready, 1);
    chk("wr_rdata_kept", d_rdata, 16'h5006);
    chk("wr_done", mem_req, 0);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int hi = 0;
      d_req = 1'b1; d_addr = 16'h0077;
      @(negedge clk);
      while (mem_req && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      chk("to_acc_cycles", hi, 15);
      chk("to_d_ready", d_ready, 1);
      chk("to_d_rdata", d_rdata, 0);
      chk("to_err", timeout_err, 1);
      d_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("to_err_sticky", timeout_err, 1);
    end
`endif

    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0055;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", {mem_req, busy}, 2'b11);
`ifndef MEM_ARB_TIMEOUT_EN
    repeat (20) @(negedge clk);
    chk("no_to_wait", mem_req, 1);
    chk("no_to_err", timeout_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {mem_req, busy}, 0);
    chk("rst_mid_no_ready", d_ready, 0);
    chk("rst_mid_rdata", d_rdata, 0);
    chk("rst_mid_err", timeout_err, 0);
    rst = 1'b1; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    repeat (2) begin
      @(negedge clk);
      chk("late_ready_ignored", {if_ready, d_ready, busy}, 0);
    end
    chk("late_rdata_ignored", d_rdata, 0);
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter D_BURST_MAX, default 4: the maximum consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15: the access watchdog limit in cycles (used only under REQ-030).
REQ-003 SHALL have port clk, in, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, in, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 16), if_rdata (out, 16), if_ready (out, 1): the instruction-fetch requester.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 16), d_wdata (in, 16), d_rdata (out, 16), d_ready (out, 1): the MEM-stage requester.
REQ-007 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 16), mem_wdata (out, 16), mem_rdata (in, 16), mem_ready (in, 1): the single shared memory port.
REQ-008 SHALL have ports if_stall (out, 1), d_stall (out, 1), busy (out, 1), timeout_err (out, 1): pipeline stall and status outputs.

Function
REQ-009 SHALL implement FSM states IDLE, IF_ACC and D_ACC.
REQ-010 SHALL choose the grant in IDLE when any req is high: data wins, except a fetch wins when if_req is high and burst_cnt == D_BURST_MAX.
REQ-011 SHALL, on a grant, register addr/we/wdata from the winner into mem_addr/mem_we/mem_wdata and enter the ACC state on the next edge.
REQ-012 SHALL hold mem_req=1 exactly while in IF_ACC or D_ACC; mem_* SHALL stay stable for the whole access.
REQ-013 SHALL, on mem_ready=1 in an ACC state, capture mem_rdata into if_rdata or d_rdata (reads only), pulse the matching ready for one cycle, and return to IDLE.
REQ-014 SHALL keep d_rdata unchanged on a write completion; d_ready still pulses.
REQ-015 SHALL give a minimum latency of 2 cycles: req sampled at edge N, mem_req high after N, mem_ready seen at N+1, ready pulse after N+1.
REQ-016 SHALL not grant a new access in the cycle a ready pulses, because the FSM passes through IDLE.
REQ-017 SHALL drive if_stall = if_req & ~if_ready and d_stall = d_req & ~d_ready combinationally.
REQ-018 SHALL drive busy = (state != IDLE).
REQ-019 SHALL manage burst_cnt (width clog2(D_BURST_MAX+1)) as follows: +1 on each data grant while if_req=1, saturating at D_BURST_MAX; cleared on a fetch grant or when if_req=0 in IDLE.
REQ-020 SHALL let an access complete and its ready pulse if the requester drops req mid-access; requesters SHALL hold req, addr and data until ready.
REQ-021 SHALL ignore mem_ready while in IDLE.
REQ-022 SHALL keep ready pulses and rdata registered (no combinational mem_rdata to output path).

Reset
REQ-023 SHALL, while rst=0 at a posedge, force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, burst_cnt=0, timeout_err=0.
REQ-024 SHALL abort an in-flight access on reset with no ready pulse; the first grant is possible at the first edge with rst=1.

Configuration
REQ-030 SHALL compile the watchdog under macro MEM_ARB_TIMEOUT_EN: a counter clears on ACC entry and increments each ACC cycle without mem_ready.
REQ-031 SHALL, with the macro defined, when the counter reaches TIMEOUT_CYCLES: drop mem_req, pulse the owner's ready with rdata=16'h0000, set timeout_err sticky until reset, and return to IDLE.
REQ-032 SHALL, without the macro, wait indefinitely for mem_ready and tie timeout_err to 0, with no counter logic.

Structure
REQ-040 SHALL place the FSM state encoding (IDLE=2'd0, IF_ACC=2'd1, D_ACC=2'd2) and the 16-bit data/address width constants in shared package mem_arb_pkg.
REQ-041 SHALL put the watchdog in one sub-module, mem_arb_timer (inputs clk, rst, start, tick; output expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-050 SHALL cover a single fetch: if_req=1, if_addr=16'h0010, mem_ready on the first ACC cycle with rdata=16'hBEEF -> if_ready pulses once 2 cycles after req, if_rdata=16'hBEEF, if_stall low in that cycle.
REQ-051 SHALL cover a collision: if_req and d_req both high in IDLE -> D_ACC granted first, with mem_addr=d_addr; fetch is served after d_ready; if_stall stays high throughout.
REQ-052 SHALL cover starvation: d_req held high for 6 back-to-back accesses plus a pending fetch, D_BURST_MAX=4 -> the 5th grant goes to the fetch, then data resumes.
REQ-053 SHALL cover a write: d_we=1, d_addr=16'h0042, d_wdata=16'h1234, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=16'h1234 held 4 cycles, d_ready pulses, d_rdata unchanged.
REQ-054 SHALL cover the timeout (macro on, TIMEOUT_CYCLES=15): mem_ready never asserts -> mem_req drops after 15 ACC cycles, d_ready pulses with d_rdata=0, timeout_err=1 until rst=0.
REQ-055 SHALL cover reset mid-access: rst=0 asserted in D_ACC -> next edge state=IDLE, mem_req=0, no d_ready pulse, and a late mem_ready is ignored.
